// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
//   Shared definitions for the PWM audio link receive path.
//   Holds default sizing (PWM resolution, sample width, period width,
//   hysteresis and loss-of-lock window) and the state enums used by the
//   frame/lock FSM and the pitch tracker.
// -----------------------------------------------------------------------------
package sound_pkg;

  localparam int N_DEFAULT           = 8;
  localparam int SAMPLE_W_DEFAULT    = N_DEFAULT + 2;
  localparam int P_W_DEFAULT         = 12;
  localparam int HYST_DEFAULT        = 4;
  localparam int LOSS_FRAMES_DEFAULT = 255;

  // Pitch tracker half-wave state
  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } trk_state_t;

  // Frame alignment state
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Width of a reconstructed sample for a given PWM resolution
  function automatic int sample_width(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/pwm_line_meter.sv
// -----------------------------------------------------------------------------
// pwm_line_meter
//   Front end for one PWM line of the differential pair.
//   Brings the asynchronous line into the clk domain, remembers its level at
//   the previous tick to flag rising edges, and counts how many ticks the line
//   was high since the last clear.
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   tick        : one-clk strobe per PWM step; the line is only sampled here
//   line        : asynchronous PWM input
//   clear       : on a tick, restart the count (with enable, this tick counts)
//   enable      : on a tick, add this tick's level to the count
//   level       : synchronised line level
//   rise        : tick with line high now and low at the previous tick
//   count_now   : high-tick count including the current tick's level
// -----------------------------------------------------------------------------
module pwm_line_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         line,
  input  logic         clear,
  input  logic         enable,
  output logic         level,
  output logic         rise,
  output logic [N:0]   count_now
);

  logic         sync1;
  logic         sync2;
  logic         prev;
  logic [N:0]   count;

  // Two-flop synchroniser runs every clock; the previous-tick level and the
  // high counter only move on tick cycles so they track PWM steps, not clocks.
  // A clear with enable restarts the count at this tick's level, which is how
  // a frame start is folded into the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      if (tick) begin
        prev <= sync2;
        if (clear) begin
          count <= enable ? {{N{1'b0}}, sync2} : '0;
        end else if (enable) begin
          count <= count_now;
        end
      end
    end
  end

  // The count seen by the frame logic already includes the current tick, so
  // a frame-end tick contributes to the sample it closes.
  assign level     = sync2;
  assign rise      = tick & sync2 & ~prev;
  assign count_now = count + {{N{1'b0}}, sync2};

endmodule

// File: rtl/pwm_pair_decoder.sv
// -----------------------------------------------------------------------------
// pwm_pair_decoder
//   Receive end of the differential PWM audio link. Locks to the PWM frame
//   using rising edges on either line, measures each line's high time per
//   frame and emits one signed sample per frame (pos - neg). A hysteretic
//   zero-crossing tracker reports the tone period in frames.
// Ports
//   clk, reset    : system clock, synchronous active-high reset
//   tick          : one-clk strobe per PWM step
//   pwm_pos/neg   : asynchronous PWM lines
//   sample        : signed N+2-bit sample, pos_cnt - neg_cnt
//   sample_valid  : one-clk strobe, sample updated
//   locked        : frame alignment held
//   sync_err      : one-clk strobe, rising edge off frame start while locked
//   overlap_err   : one-clk strobe, both lines high on the same tick
//   period        : frames between successive upward zero crossings
//   period_valid  : one-clk strobe, period updated
// -----------------------------------------------------------------------------
module pwm_pair_decoder
  import sound_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int P_W         = P_W_DEFAULT,
  parameter int HYST        = HYST_DEFAULT,
  parameter int LOSS_FRAMES = LOSS_FRAMES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                pwm_pos,
  input  logic                pwm_neg,
  output logic [N+1:0]        sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                overlap_err,
  output logic [P_W-1:0]      period,
  output logic                period_valid
);

  localparam int                    LW         = $clog2(LOSS_FRAMES + 1);
  localparam logic [N-1:0]          FRAME_LAST = '1;
  localparam logic [P_W-1:0]        PCNT_MAX   = '1;
  localparam logic signed [N+1:0]   HYST_POS   = (N+2)'(HYST);
  localparam logic signed [N+1:0]   HYST_NEG   = -HYST_POS;

  lock_state_t         state, state_next;
  logic [N-1:0]        fcnt, fcnt_next;
  logic [LW-1:0]       loss_cnt, loss_next;
  logic                frame_rise, frame_rise_next;

  trk_state_t          trk, trk_next;
  logic                armed, armed_next;
  logic [P_W-1:0]      pcnt, pcnt_next, pcnt_inc;
  logic                period_fire;

  logic                meter_clear, meter_enable;
  logic                pos_level, neg_level, pos_rise, neg_rise, any_rise;
  logic [N:0]          pos_now, neg_now;
  logic                emit, resync, drop_lock, overlap;
  logic signed [N+1:0] sample_next;

  pwm_line_meter #(.N(N)) u_pos (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .line      (pwm_pos),
    .clear     (meter_clear),
    .enable    (meter_enable),
    .level     (pos_level),
    .rise      (pos_rise),
    .count_now (pos_now)
  );

  pwm_line_meter #(.N(N)) u_neg (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .line      (pwm_neg),
    .clear     (meter_clear),
    .enable    (meter_enable),
    .level     (neg_level),
    .rise      (neg_rise),
    .count_now (neg_now)
  );

  assign any_rise    = pos_rise | neg_rise;
  assign sample_next = $signed({1'b0, pos_now}) - $signed({1'b0, neg_now});
  assign locked      = (state == LOCKED);

  // Frame/lock FSM. A rising edge while unlocked, or off position 0 while
  // locked, restarts the frame with this tick as position 0. Resync is tested
  // before frame end so an edge on the last tick drops the partial frame.
  // The loss counter only counts complete frames that saw no rising edge.
  always_comb begin
    state_next      = state;
    fcnt_next       = fcnt;
    loss_next       = loss_cnt;
    frame_rise_next = frame_rise;
    meter_clear     = 1'b0;
    meter_enable    = 1'b0;
    emit            = 1'b0;
    resync          = 1'b0;
    drop_lock       = 1'b0;
    overlap         = 1'b0;
    if (tick) begin
      case (state)
        UNLOCKED: begin
          if (any_rise) begin
            state_next      = LOCKED;
            fcnt_next       = N'(1);
            meter_clear     = 1'b1;
            meter_enable    = 1'b1;
            loss_next       = '0;
            frame_rise_next = 1'b1;
          end
        end
        LOCKED: begin
          overlap = pos_level & neg_level;
          if (any_rise && (fcnt != '0)) begin
            resync          = 1'b1;
            fcnt_next       = N'(1);
            meter_clear     = 1'b1;
            meter_enable    = 1'b1;
            loss_next       = '0;
            frame_rise_next = 1'b1;
          end else if (fcnt == FRAME_LAST) begin
            emit            = 1'b1;
            meter_clear     = 1'b1;
            fcnt_next       = '0;
            frame_rise_next = 1'b0;
            if (frame_rise) begin
              loss_next = '0;
            end else if (loss_cnt == LW'(LOSS_FRAMES - 1)) begin
              drop_lock  = 1'b1;
              state_next = UNLOCKED;
              loss_next  = '0;
            end else begin
              loss_next = loss_cnt + 1'b1;
            end
          end else begin
            meter_enable = 1'b1;
            fcnt_next    = fcnt + 1'b1;
            if (any_rise) begin
              frame_rise_next = 1'b1;
            end
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  // Pitch tracker, advanced once per emitted sample. The period reported on
  // an upward crossing is the pcnt value before this sample, because the
  // previous crossing's sample was already counted as 1. Losing lock puts the
  // tracker back to its post-reset state so a stale half-cycle never yields a
  // period.
  always_comb begin
    trk_next    = trk;
    armed_next  = armed;
    pcnt_next   = pcnt;
    period_fire = 1'b0;
    pcnt_inc    = (pcnt == PCNT_MAX) ? pcnt : pcnt + 1'b1;
    if (drop_lock) begin
      trk_next   = NEG;
      armed_next = 1'b0;
      pcnt_next  = '0;
    end else if (emit) begin
      case (trk)
        NEG: begin
          if (sample_next > HYST_POS) begin
            period_fire = armed && (pcnt != PCNT_MAX);
            trk_next    = POS;
            pcnt_next   = P_W'(1);
            armed_next  = 1'b1;
          end else begin
            pcnt_next = pcnt_inc;
          end
        end
        POS: begin
          if (sample_next < HYST_NEG) begin
            trk_next = NEG;
          end
          pcnt_next = pcnt_inc;
        end
        default: trk_next = NEG;
      endcase
    end
  end

  // State and output registers. Strobes follow the tick by one clock;
  // sample and period hold their last value between updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= UNLOCKED;
      fcnt         <= '0;
      loss_cnt     <= '0;
      frame_rise   <= 1'b0;
      trk          <= NEG;
      armed        <= 1'b0;
      pcnt         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
      overlap_err  <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_next;
      fcnt         <= fcnt_next;
      loss_cnt     <= loss_next;
      frame_rise   <= frame_rise_next;
      trk          <= trk_next;
      armed        <= armed_next;
      pcnt         <= pcnt_next;
      sample_valid <= emit;
      sync_err     <= resync;
      overlap_err  <= overlap;
      period_valid <= period_fire;
      if (emit) begin
        sample <= sample_next;
      end
      if (period_fire) begin
        period <= pcnt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_pair_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_pair_decoder
//   Self-checking bench for pwm_pair_decoder. Frames are generated the way the
//   dac pair drives them (line high for t_on steps from frame position 0);
//   expected samples and periods are queued when a frame is driven and
//   compared as the DUT emits them.
// -----------------------------------------------------------------------------
module tb_pwm_pair_decoder;

  localparam int N        = 8;
  localparam int P_W      = 12;
  localparam int HYST     = 4;
  localparam int LOSS     = 16;
  localparam int FRAME    = 256;
  localparam int PCNT_MAX = (1 << P_W) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tick = 1'b0;
  logic           pwm_pos = 1'b0;
  logic           pwm_neg = 1'b0;
  logic [N+1:0]   sample;
  logic           sample_valid;
  logic           locked;
  logic           sync_err;
  logic           overlap_err;
  logic [P_W-1:0] period;
  logic           period_valid;

  int checks = 0;
  int failures = 0;
  int tick_gap = 1;
  int exp_sample_q[$];
  int exp_period_q[$];
  int sync_cnt = 0;
  int overlap_cnt = 0;
  int period_cnt = 0;
  int mon_exp;
  bit m_pos;
  bit m_armed;
  int m_pcnt;

  // Shorter loss window than the default keeps the loss scenario brief.
  pwm_pair_decoder #(
    .N           (N),
    .P_W         (P_W),
    .HYST        (HYST),
    .LOSS_FRAMES (LOSS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .pwm_pos      (pwm_pos),
    .pwm_neg      (pwm_neg),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .sync_err     (sync_err),
    .overlap_err  (overlap_err),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  // Output monitor: counts error strobes and pops the scoreboard whenever a
  // sample or period is emitted.
  always @(negedge clk) begin
    if (!reset) begin
      if (sync_err) sync_cnt++;
      if (overlap_err) overlap_cnt++;
      if (sample_valid) begin
        checks++;
        if (exp_sample_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL sample_unexpected: got %0d, required no sample", $signed(sample));
        end else begin
          mon_exp = exp_sample_q.pop_front();
          if ($signed(sample) !== mon_exp) begin
            failures++;
            $display("[TB] FAIL sample_value: got %0d, required %0d", $signed(sample), mon_exp);
          end
        end
      end
      if (period_valid) begin
        period_cnt++;
        checks++;
        if (exp_period_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL period_unexpected: got %0d, required no period", period);
        end else begin
          mon_exp = exp_period_q.pop_front();
          if (int'(period) !== mon_exp) begin
            failures++;
            $display("[TB] FAIL period_value: got %0d, required %0d", period, mon_exp);
          end
        end
      end
    end
  end

  // Pitch model: NEG/POS with hysteresis, saturating frame count per sample.
  task automatic model_reset();
    m_pos   = 1'b0;
    m_armed = 1'b0;
    m_pcnt  = 0;
  endtask

  task automatic expect_sample(input int s);
    exp_sample_q.push_back(s);
    if (!m_pos && (s > HYST)) begin
      if (m_armed && (m_pcnt != PCNT_MAX)) exp_period_q.push_back(m_pcnt);
      m_pos   = 1'b1;
      m_armed = 1'b1;
      m_pcnt  = 1;
    end else begin
      if (m_pos && (s < -HYST)) m_pos = 1'b0;
      if (m_pcnt != PCNT_MAX) m_pcnt++;
    end
  endtask

  // One PWM step: lines change, then tick strobes tick_gap clocks later.
  task automatic applyStimulus(input logic p, input logic n);
    @(negedge clk);
    pwm_pos = p;
    pwm_neg = n;
    if (tick_gap > 1) begin
      tick = 1'b0;
      repeat (tick_gap - 1) @(negedge clk);
    end
    tick = 1'b1;
  endtask

  task automatic drive_frame(input int pos_on, input int neg_on, input bit expect_it);
    if (expect_it) expect_sample(pos_on - neg_on);
    for (int b = 0; b < FRAME; b++) applyStimulus(b < pos_on, b < neg_on);
  endtask

  task automatic idle(input int steps);
    for (int i = 0; i < steps; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;
    repeat (4) @(negedge clk);
    exp_sample_q.delete();
    exp_period_q.delete();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if ((exp_sample_q.size() != 0) || (exp_period_q.size() != 0)) begin
      failures++;
      $display("[TB] FAIL %s_drained: got %0d samples / %0d periods pending, required 0 / 0",
               name, exp_sample_q.size(), exp_period_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({sample, sample_valid, locked, sync_err, overlap_err, period, period_valid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got sample=%0d sv=%0b locked=%0b se=%0b oe=%0b period=%0d pv=%0b, required all 0",
               sample, sample_valid, locked, sync_err, overlap_err, period, period_valid);
    end
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_locked: got %0b, required 0", locked);
    end
  endtask

  task automatic test_positive();
    do_reset();
    tick_gap = 3;
    for (int f = 0; f < 3; f++) drive_frame(128, 0, 1'b1);
    idle(4);
    check_drained("positive");
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL positive_locked: got %0b, required 1", locked);
    end
    checks++;
    if ((sync_cnt != 0) || (overlap_cnt != 0)) begin
      failures++;
      $display("[TB] FAIL positive_errors: got sync=%0d overlap=%0d, required 0 0", sync_cnt, overlap_cnt);
    end
  endtask

  task automatic test_negative_and_silence();
    do_reset();
    tick_gap = 1;
    drive_frame(0, 200, 1'b1);
    for (int f = 0; f < 10; f++) drive_frame(0, 0, 1'b1);
    idle(4);
    check_drained("silence");
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL silence_locked: got %0b, required 1", locked);
    end
  endtask

  task automatic test_loss();
    do_reset();
    drive_frame(50, 0, 1'b1);
    for (int f = 0; f < LOSS - 1; f++) drive_frame(0, 0, 1'b1);
    idle(FRAME / 2);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loss_held_locked: got %0b, required 1", locked);
    end
    expect_sample(0);
    idle(FRAME / 2);
    model_reset();
    idle(3 * FRAME);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loss_dropped_locked: got %0b, required 0", locked);
    end
    check_drained("loss");
  endtask

  task automatic test_resync();
    int sync0;
    do_reset();
    sync0 = sync_cnt;
    drive_frame(100, 0, 1'b1);
    drive_frame(100, 0, 1'b1);
    for (int b = 0; b < 77; b++) applyStimulus(b < 30, 1'b0);
    drive_frame(100, 0, 1'b1);
    drive_frame(100, 0, 1'b1);
    drive_frame(0, 0, 1'b1);
    checks++;
    if ((sync_cnt - sync0) != 1) begin
      failures++;
      $display("[TB] FAIL resync_sync_err: got %0d pulses, required 1", sync_cnt - sync0);
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL resync_locked: got %0b, required 1", locked);
    end
  endtask

  task automatic test_overlap();
    int ov0;
    int sy0;
    ov0 = overlap_cnt;
    sy0 = sync_cnt;
    drive_frame(10, 10, 1'b1);
    drive_frame(0, 0, 1'b1);
    drive_frame(40, 25, 1'b1);
    idle(4);
    check_drained("overlap");
    checks++;
    if ((overlap_cnt - ov0) != 35) begin
      failures++;
      $display("[TB] FAIL overlap_pulses: got %0d, required 35", overlap_cnt - ov0);
    end
    checks++;
    if ((sync_cnt - sy0) != 0) begin
      failures++;
      $display("[TB] FAIL overlap_sync_err: got %0d, required 0", sync_cnt - sy0);
    end
  endtask

  task automatic test_pitch_and_reset();
    real x;
    int  s;
    int  p0;
    int  sy0;
    do_reset();
    p0 = period_cnt;
    for (int k = 0; k < 100; k++) begin
      x = 100.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 40.0);
      s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
      drive_frame((s > 0) ? s : 0, (s < 0) ? -s : 0, k > 0);
    end
    for (int b = 0; b < 128; b++) applyStimulus(b < 70, 1'b0);
    checks++;
    if ((period_cnt - p0) != 2) begin
      failures++;
      $display("[TB] FAIL pitch_period_count: got %0d, required 2", period_cnt - p0);
    end
    check_drained("pitch");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sample, sample_valid, locked, sync_err, overlap_err, period, period_valid} !== '0) begin
      failures++;
      $display("[TB] FAIL midframe_reset_outputs: got sample=%0d locked=%0b period=%0d, required all 0",
               sample, locked, period);
    end
    model_reset();
    pwm_pos = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sy0 = sync_cnt;
    for (int f = 0; f < 3; f++) drive_frame(60, 0, 1'b1);
    idle(4);
    check_drained("relock");
    checks++;
    if ((locked !== 1'b1) || ((sync_cnt - sy0) != 0)) begin
      failures++;
      $display("[TB] FAIL relock_state: got locked=%0b sync=%0d, required 1 0", locked, sync_cnt - sy0);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    $display("[TB] start");
    test_reset();
    test_positive();
    test_negative_and_silence();
    test_loss();
    test_resync();
    test_overlap();
    test_pitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
